// File: rtl/sliding_window_kxk.sv
// Streaming KxK window generator: raster pixels in, strided KxK neighbourhoods out, valid/ready on both sides.
// Optional macro SW_COORD_EN adds win_row/win_col (top-left coordinate of the current window).
module sliding_window_kxk #(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int IMG_W  = 130,
  parameter int IMG_H  = 130,
  parameter int STRIDE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        pixel_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [K*K*DATA_W-1:0]    win_out,
  output logic                     frame_done
`ifdef SW_COORD_EN
  ,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col
`endif
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(STRIDE - 1);

  logic                  accept;
  logic                  emit;
  logic                  col_wrap;
  logic                  row_wrap;

  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [PH_W-1:0]       col_ph_q, col_ph_d;
  logic [PH_W-1:0]       row_ph_q, row_ph_d;
  logic [COL_W-1:0]      rd_addr;

  logic                  out_valid_q, out_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic [K*K*DATA_W-1:0] win_q;
  logic [K*K*DATA_W-1:0] win_d;

  // col_vec[0] is the oldest row of the incoming column, col_vec[K-1] the live pixel.
  logic [DATA_W-1:0]     col_vec [K];
  logic [DATA_W-1:0]     sh_q [K][K];
  logic [DATA_W-1:0]     sh_d [K][K];

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_wrap = (col_q == COL_LAST);
  assign row_wrap = (row_q == ROW_LAST);

  // Stride phases count only once the axis has reached K-1, so phase 0 marks an emitting position.
  assign emit = accept && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST) &&
                (row_ph_q == '0) && (col_ph_q == '0);

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    col_ph_d = col_ph_q;
    row_ph_d = row_ph_q;
    if (accept) begin
      if (col_wrap) begin
        col_d    = '0;
        col_ph_d = '0;
        if (row_wrap) begin
          row_d    = '0;
          row_ph_d = '0;
        end else begin
          row_d = row_q + 1'b1;
          if (row_q >= ROW_FIRST) begin
            row_ph_d = (row_ph_q == PH_LAST) ? '0 : row_ph_q + 1'b1;
          end
        end
      end else begin
        col_d = col_q + 1'b1;
        if (col_q >= COL_FIRST) begin
          col_ph_d = (col_ph_q == PH_LAST) ? '0 : col_ph_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    frame_done_d = accept && col_wrap && row_wrap;
    if (emit) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Line buffers read one column ahead so the RAM read can be registered.
  assign rd_addr = rst ? '0 : col_d;

  assign col_vec[K-1] = pixel_in;

  genvar gi, gj;
  generate
    for (gi = 0; gi < K - 1; gi++) begin : g_line
      logic [DATA_W-1:0] mem_q [IMG_W];
      logic [DATA_W-1:0] rd_q;

      always_ff @(posedge clk) begin
        if (accept) begin
          mem_q[col_q] <= col_vec[gi+1];
        end
        rd_q <= mem_q[rd_addr];
      end

      assign col_vec[gi] = rd_q;
    end

    for (gi = 0; gi < K; gi++) begin : g_row
      for (gj = 0; gj < K; gj++) begin : g_col
        if (gj == K - 1) begin : g_new
          assign sh_d[gi][gj] = col_vec[gi];
        end else begin : g_shift
          assign sh_d[gi][gj] = sh_q[gi][gj+1];
        end
        assign win_d[(gi*K+gj)*DATA_W +: DATA_W] = sh_d[gi][gj];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (accept) begin
      sh_q <= sh_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      col_ph_q     <= '0;
      row_ph_q     <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_q        <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      col_ph_q     <= col_ph_d;
      row_ph_q     <= row_ph_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      if (emit) begin
        win_q <= win_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign win_out    = win_q;

`ifdef SW_COORD_EN
  logic [ROW_W-1:0] win_row_q;
  logic [COL_W-1:0] win_col_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_row_q <= '0;
      win_col_q <= '0;
    end else if (emit) begin
      win_row_q <= row_q - ROW_FIRST;
      win_col_q <= col_q - COL_FIRST;
    end
  end

  assign win_row = win_row_q;
  assign win_col = win_col_q;
`endif

endmodule

// File: doc/sliding_window_kxk.md
Name:
sliding_window_kxk

Overview:
Parametrised streaming KxK window generator for the CNN datapath. It takes a raster-order pixel stream and emits complete KxK neighbourhoods to the conv PE array.
- Generalises the fixed 3x3 8-bit generator to any K, data width, image size and stride.
- Adds valid/ready backpressure and frame-end tracking.
- Never emits windows that wrap across a row boundary.

Parameters:
DATA_W, 8, bits per pixel (signed, passed through unmodified)
K, 3, window edge; legal 2..7
IMG_W, 130, pixels per row; must be >= K
IMG_H, 130, rows per frame; must be >= K
STRIDE, 1, horizontal and vertical window step; legal 1..K

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  pixel_in valid
in_ready  out  1  block can accept pixel_in this cycle
pixel_in  in  DATA_W  signed input pixel, raster order
out_valid  out  1  win_out holds a valid window
out_ready  in  1  downstream accepts win_out this cycle
win_out  out  K*K*DATA_W  window; element i=r*K+c at bits [i*DATA_W +: DATA_W], r=0 oldest row, c=0 leftmost column
frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted

Behaviour:
- One clock; reset is synchronous and active-high. All state is cleared on the rst edge: clk rising with rst=1.
- Reset values: out_valid=0, win_out=0, frame_done=0, col_cnt=0, row_cnt=0.
- in_ready = !out_valid || out_ready. It is combinational and has a single output stage.
- Accept: in_valid && in_ready. Every internal register advances only on accept; idle cycles hold all state.
- Storage:
  - K-1 line buffers of IMG_W x DATA_W; each accept shifts column col_cnt up one line.
  - KxK shift array; each row takes the new column from the line buffers plus pixel_in.
- Counters:
  - col_cnt wraps IMG_W-1 -> 0 and then increments row_cnt.
  - row_cnt wraps IMG_H-1 -> 0 at frame end.
- Emit condition on an accept of pixel (row_cnt, col_cnt), all of:
  - row_cnt >= K-1 and col_cnt >= K-1
  - (row_cnt-(K-1)) % STRIDE == 0
  - (col_cnt-(K-1)) % STRIDE == 0
- Latency: on an emitting accept, win_out is loaded with the window whose bottom-right is that pixel, and out_valid=1 on the next cycle.
- Output hold: win_out and out_valid hold while out_valid && !out_ready.
- Non-emitting accept, or no accept, with out_ready=1: out_valid drops to 0.
- Simultaneous out_ready and emitting accept: the new window replaces the old one with no bubble, so full throughput is 1 window/cycle.
- Windows per frame: ((IMG_H-K)/STRIDE+1)*((IMG_W-K)/STRIDE+1).
- Stale data: shift-array contents from the previous row (col < K-1) are never emitted.
- frame_done: pulses high for one cycle, the cycle after accepting pixel (IMG_H-1, IMG_W-1).
- Back-to-back frames: the next frame starts on the next accept with no gap required. Line buffers are not cleared; old data is never emitted because rows < K-1 do not emit.
- Reset mid-frame: counters and the output stage are cleared immediately. The next accepted pixel is treated as (0,0); line buffer contents are don't-care.
- Modulo logic: implement with per-axis stride phase counters, not dividers.

Optional Feature:
Macro SW_COORD_EN.
- Defined: adds outputs win_row [$clog2(IMG_H)-1:0] and win_col [$clog2(IMG_W)-1:0].
  - Both give the top-left coordinate of the current win_out window, i.e. emitting row_cnt-(K-1) and col_cnt-(K-1).
  - They are registered with win_out, hold under backpressure, and reset to 0.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Basic 3x3: K=3, IMG_W=5, IMG_H=4, STRIDE=1, pixel=r*5+c, in_valid=1, out_ready=1 -> exactly 6 windows.
  - First window one cycle after accepting pixel 12: {0,1,2,5,6,7,10,11,12}.
  - Last window: {7,8,9,12,13,14,17,18,19}.
  - No window emitted for col<2.
- Stride: K=3, IMG_W=5, IMG_H=5, STRIDE=2 -> exactly 4 windows, bottom-right pixels 12, 14, 22, 24.
  - Window for 24: {12,13,14,17,18,19,22,23,24}.
- Backpressure: basic config, out_ready=0 from cycle 0 -> after first window out_valid stays 1 and in_ready=0.
  - win_out is held unchanged.
  - Releasing out_ready resumes; all 6 windows arrive in order, none lost or duplicated.
- Random valid/ready: 50% random in_valid and out_ready, K=4, IMG_W=9, IMG_H=6, DATA_W=8, signed values including -128 and 127 -> window sequence matches the reference model bit-exact; sign bits intact.
- Back-to-back frames and frame_done: two basic-config frames with no gap -> frame_done high exactly 1 cycle after pixels 19 and 39.
  - Second frame yields the same 6 windows, offset by +20.
- Reset mid-frame: assert rst for 1 cycle after pixel 8 is accepted -> out_valid=0 next cycle.
  - Restarting the stream at 0 yields exactly 6 windows identical to the basic test.
  - With SW_COORD_EN, win_row/win_col of the first window = 0/0.
